keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Sequencer for the calculator's 4x4 key matrix. It drives the column lines one at a time and samples the row lines after a settling interval. It debounces whole-matrix scan frames and emits one clean key event per physical press. It sits between the board keypad pins (`key_out`/`key_in`) and the calculator's entry logic, replacing ad-hoc polling in the top level.

## Interface
- `SCAN_DIV`, default 100000: clk cycles each column is driven before its rows are sampled; legal range ≥ 4.
- `DEBOUNCE_CNT`, default 3: consecutive identical frame results required to commit a change; legal range ≥ 1.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `key_in`  in  4  row inputs, active-low (pulled up; 4'b1111 = no key); asynchronous to `clk`.
- `key_out`  out  4  column drive, exactly one bit low at all times.
- `key_code`  out  4  committed key, `{col[1:0], row[1:0]}` (0..15).
- `key_valid`  out  1  one-cycle pulse when a new key is committed.
- `key_held`  out  1  high while the committed key is debounced-down.
- `multi_key`  out  1  high while the last committed frame class is MULTI.

## Operation
- `key_in` passes through a 2-flop synchronizer before use.
- Column index `col` selects the column; `key_out = ~(4'b0001 << col)`.
- The dwell counter runs 0..SCAN_DIV-1.
  - At SCAN_DIV-1: the synchronized rows are stored into `rows[col]`, `col` increments (wraps 3→0), and the counter clears.
- Frame end is the sample taken at col 3. At frame end the frame is classified over the 16 row bits:
  - NONE: no bit low.
  - ONE(c): exactly one bit low; c = col*4 + row index, where `key_in[0]` is row 0.
  - MULTI: two or more bits low.
- Stability counter:
  - Incremented (saturating at DEBOUNCE_CNT) when the frame class and code equal the previous frame's.
  - Otherwise set to 1.
  - A class is "stable" on the frame where the counter reaches DEBOUNCE_CNT.
- Controller states:
  - IDLE:
    - stable ONE(c) → PRESSED; `key_code`←c, `key_valid` pulse, `key_held`←1.
    - stable MULTI → WAIT_RELEASE.
  - PRESSED:
    - stable NONE → IDLE; `key_held`←0.
    - stable MULTI, or stable ONE(c') with c'≠c → WAIT_RELEASE; `key_held`←0.
  - WAIT_RELEASE:
    - stable NONE → IDLE. No events are emitted in this state (no rollover).
- `multi_key` is 1 from the frame in which MULTI becomes stable until the frame in which any other class becomes stable.
- `key_code` holds its last value until the next commit.

## Timing
- Reset values:
  - `key_out`=4'b1110 (col 0), `key_code`=0, `key_valid`=0, `key_held`=0, `multi_key`=0.
  - State IDLE; all counters 0; `rows` = all ones; previous class = NONE.
- One frame = 4·SCAN_DIV cycles.
- The sampled value reflects `key_in` from 2 cycles earlier (synchronizer). SCAN_DIV ≥ 4 guarantees the sample is settled after a column change.
- Press latency:
  - `key_valid` rises 1 cycle after the frame-end sample of the qualifying frame.
  - That is at most (DEBOUNCE_CNT+1) frames + 3 cycles after the press becomes clean.
- Release latency: `key_held` falls on the same cycle position, after DEBOUNCE_CNT NONE frames.
- `key_valid` never asserts on two consecutive cycles.
- With DEBOUNCE_CNT=1, every frame-end may commit.
- Reset asserted mid-frame or mid-press:
  - All outputs take reset values immediately.
  - After release, scanning restarts at col 0 with a fresh frame.
  - A key still held produces a new `key_valid` after debounce.

## Structure
- Shared package `calc_pkg`:
  - state enum {IDLE, PRESSED, WAIT_RELEASE};
  - frame class enum {NONE, ONE, MULTI};
  - constants `KEY_ROWS=4`, `KEY_COLS=4`, `ROWS_IDLE=4'b1111`.
- Sub-module `sync_2ff` (4 bits wide, async reset to 1s) for `key_in`.
- Column sequencer, frame classifier, and debounce FSM live in `keypad_scanner`.

## Test plan
Bench parameters: SCAN_DIV=8, DEBOUNCE_CNT=2, matrix model pulling row r low when column c is driven low and key (c,r) is down.
- Reset:
  - `key_out`=1110 and all other outputs 0.
  - Free run: `key_out` sequence 1110→1101→1011→0111→1110, each value held exactly 8 cycles.
- Hold key (col 2, row 1) for 6 frames → exactly one `key_valid` with `key_code`=9, `key_held`=1. Release → `key_held`=0 after 2 NONE frames, no further pulse.
- Key 9 bouncing (toggled every frame for 6 frames) → no `key_valid`, `key_held` stays 0. Then hold steady → single pulse with code 9.
- Press codes 0 and 5 together:
  - `multi_key`=1, no `key_valid`.
  - Release code 0 only → still no event (WAIT_RELEASE).
  - Release all, then press 5 → `key_valid` with `key_code`=5, `multi_key`=0.
- Assert `rst` for 3 cycles while PRESSED with code 15 held → outputs reset asynchronously. After release with key still down → new `key_valid`, code 15, within 3 frames + 3 cycles.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the calculator keypad path
package calc_pkg;
    typedef enum logic [1:0] {IDLE, PRESSED, WAIT_RELEASE} state_t;
    typedef enum logic [1:0] {NONE, ONE, MULTI} fclass_t;
    localparam int KEY_ROWS = 4;
    localparam int KEY_COLS = 4;
    localparam logic [3:0] ROWS_IDLE = 4'b1111;
endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad pins plus committed-key outputs
// master = scanner side (drives key_out and key events, reads key_in)
// slave  = board/consumer side
interface keypad_scanner_if;
    logic [3:0] key_in;
    logic [3:0] key_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       multi_key;
    modport master (input key_in, output key_out, key_code, key_valid, key_held, multi_key);
    modport slave (output key_in, input key_out, key_code, key_valid, key_held, multi_key);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer, async reset to all ones
// clk/rst: clock and async active-high reset; d: async input; q: synchronized output
module sync_2ff #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] s1;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            s1 <= '1;
            q  <= '1;
        end else begin
            s1 <= d;
            q  <= s1;
        end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix column sequencer, frame debouncer and key event FSM
// clk/rst: clock and async active-high reset
// kp: key_in rows (active-low), key_out column drive, key_code/key_valid/key_held/multi_key events
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int DEBOUNCE_CNT = 3
) (
    input logic               clk,
    input logic               rst,
    keypad_scanner_if.master  kp
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int SW = $clog2(DEBOUNCE_CNT + 1);
    logic [3:0]    rows_s;
    logic [CW-1:0] cnt;
    logic [1:0]    col;
    logic [3:0]    rows [KEY_COLS];
    logic          tick, frame_end, same, stable;
    logic [15:0]   frame;
    logic [4:0]    nlow;
    logic [3:0]    fidx, fkey, prev_code;
    fclass_t       fcls, prev_cls;
    logic [SW-1:0] stab, stab_n;
    state_t        state, state_d;
    logic [3:0]    code_q, code_d;
    logic          valid_q, valid_d, held_q, held_d, multi_q, multi_d;

    sync_2ff #(.W(KEY_ROWS)) u_sync (.clk(clk), .rst(rst), .d(kp.key_in), .q(rows_s));

    assign tick      = cnt == CW'(SCAN_DIV - 1);
    assign frame_end = tick && col == 2'd3;
    assign kp.key_out = ~(4'b0001 << col);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt  <= '0;
            col  <= '0;
            rows <= '{default: ROWS_IDLE};
        end else if (tick) begin
            rows[col] <= rows_s;
            col       <= col + 2'd1;
            cnt       <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end

    // Column 3 is taken straight from the synchronizer since it is stored on this same edge.
    assign frame = {rows_s, rows[2], rows[1], rows[0]};

    always_comb begin
        nlow = '0;
        fidx = '0;
        for (int i = 0; i < 16; i++)
            if (!frame[i]) begin
                nlow = nlow + 5'd1;
                fidx = 4'(i);
            end
        fcls = nlow == 5'd0 ? NONE : nlow == 5'd1 ? ONE : MULTI;
        // Code is zeroed for NONE/MULTI so class+code equality is a plain compare.
        fkey = fcls == ONE ? fidx : 4'd0;
    end

    assign same   = fcls == prev_cls && fkey == prev_code;
    assign stab_n = !same ? SW'(1) : stab == SW'(DEBOUNCE_CNT) ? stab : stab + SW'(1);
    assign stable = frame_end && stab_n == SW'(DEBOUNCE_CNT);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            prev_cls  <= NONE;
            prev_code <= '0;
            stab      <= '0;
        end else if (frame_end) begin
            prev_cls  <= fcls;
            prev_code <= fkey;
            stab      <= stab_n;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= IDLE;
            code_q  <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            state   <= state_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
            multi_q <= multi_d;
        end

    always_comb begin
        state_d = state;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;
        multi_d = multi_q;
        if (stable) begin
            multi_d = fcls == MULTI;
            case (state)
                IDLE:
                    if (fcls == ONE) begin
                        state_d = PRESSED;
                        code_d  = fkey;
                        valid_d = 1'b1;
                        held_d  = 1'b1;
                    end else if (fcls == MULTI) begin
                        state_d = WAIT_RELEASE;
                    end
                PRESSED:
                    if (fcls == NONE) begin
                        state_d = IDLE;
                        held_d  = 1'b0;
                    end else if (fcls == MULTI || fkey != code_q) begin
                        state_d = WAIT_RELEASE;
                        held_d  = 1'b0;
                    end
                default:
                    state_d = fcls == NONE ? IDLE : WAIT_RELEASE;
            endcase
        end
    end

    assign kp.key_code  = code_q;
    assign kp.key_valid = valid_q;
    assign kp.key_held  = held_q;
    assign kp.multi_key = multi_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboard bench for keypad_scanner with a 4x4 matrix model
module tb_keypad_scanner;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] keys = '0;
    int          total = 0;
    int          bad = 0;
    int          nev = 0;
    int          start_ev;
    int          e;
    int          expq[$];
    logic        prev_v = 1'b0;
    logic [3:0]  ex;

    keypad_scanner_if kp_if ();

    keypad_scanner #(.SCAN_DIV(8), .DEBOUNCE_CNT(2)) dut (
        .clk(clk),
        .rst(rst),
        .kp(kp_if)
    );

    always #5 clk = ~clk;

    // Matrix: row r pulled low while column c is driven low and key (c,r) is down.
    always_comb begin
        kp_if.key_in = 4'b1111;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!kp_if.key_out[c] && keys[c*4+r])
                    kp_if.key_in[r] = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic frames(input int n);
        repeat (n * 32) @(negedge clk);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_key_out", kp_if.key_out, 4'b1110);
        chk("rst_key_code", kp_if.key_code, 0);
        chk("rst_key_valid", kp_if.key_valid, 0);
        chk("rst_key_held", kp_if.key_held, 0);
        chk("rst_multi_key", kp_if.multi_key, 0);
    endtask

    always @(negedge clk) begin
        if (kp_if.key_valid) begin
            nev++;
            chk("valid_gap", prev_v, 0);
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: code got %0d expected no event", kp_if.key_code);
            end else begin
                e = expq.pop_front();
                chk("key_code", kp_if.key_code, e);
                chk("held_at_valid", kp_if.key_held, 1);
            end
        end
        prev_v = kp_if.key_valid;
    end

    initial begin
        #2 rst = 1'b1;
        #1 chk_reset_outputs();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int p = 0; p < 40; p++) begin
            ex = ~(4'b0001 << ((p / 8) % 4));
            chk("scan_seq", kp_if.key_out, ex);
            @(negedge clk);
        end

        expq.push_back(9);
        keys[9] = 1'b1;
        frames(6);
        chk("hold9_held", kp_if.key_held, 1);
        chk("hold9_code", kp_if.key_code, 9);
        chk("hold9_events", nev, 1);
        keys[9] = 1'b0;
        frames(4);
        chk("rel9_held", kp_if.key_held, 0);

        for (int i = 0; i < 6; i++) begin
            keys[9] = ~keys[9];
            chk("bounce_held", kp_if.key_held, 0);
            frames(1);
        end
        keys[9] = 1'b0;
        chk("bounce_events", nev, 1);
        expq.push_back(9);
        keys[9] = 1'b1;
        frames(4);
        chk("steady9_held", kp_if.key_held, 1);
        chk("steady9_events", nev, 2);
        keys[9] = 1'b0;
        frames(4);

        keys[0] = 1'b1;
        keys[5] = 1'b1;
        frames(4);
        chk("multi_flag", kp_if.multi_key, 1);
        chk("multi_held", kp_if.key_held, 0);
        chk("multi_events", nev, 2);
        keys[0] = 1'b0;
        frames(4);
        chk("wait_rel_held", kp_if.key_held, 0);
        chk("wait_rel_events", nev, 2);
        chk("wait_rel_multi", kp_if.multi_key, 0);
        keys[5] = 1'b0;
        frames(4);
        expq.push_back(5);
        keys[5] = 1'b1;
        frames(4);
        chk("key5_multi", kp_if.multi_key, 0);
        chk("key5_held", kp_if.key_held, 1);
        chk("key5_events", nev, 3);
        keys[5] = 1'b0;
        frames(4);

        expq.push_back(15);
        keys[15] = 1'b1;
        frames(4);
        chk("key15_held", kp_if.key_held, 1);
        chk("key15_code", kp_if.key_code, 15);
        chk("key15_events", nev, 4);
        rst = 1'b1;
        #1 chk_reset_outputs();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        expq.push_back(15);
        start_ev = nev;
        for (int i = 0; i < 99 && nev == start_ev; i++) @(posedge clk);
        @(posedge clk);
        chk("relatch_in_time", nev, start_ev + 1);
        keys[15] = 1'b0;
        frames(4);
        chk("queue_drained", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
